// File: rtl/fpnew_pkg.sv
// Shared opgroup definitions.
//   order_mode_e    : how a multi-slice opgroup returns results
//   order_cnt_width : bits needed to count 0..depth outstanding operations
package fpnew_pkg;

    typedef enum logic {
        ORDER_RR    = 1'b0,   // round-robin return, grant locked while stalled
        ORDER_ISSUE = 1'b1    // results leave strictly in issue order
    } order_mode_e;

    function automatic int unsigned order_cnt_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fpnew_order_fifo.sv
// Index FIFO recording which slice each outstanding operation went to.
// Pointers wrap at Depth, so any Depth >= 1 works, not only powers of two.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : synchronous clear, wins over push/pop
//   push_i/data_i : enqueue a slice index (ignored when full)
//   pop_i         : dequeue the head (ignored when empty)
//   data_o        : head entry
//   full_o/empty_o/usage_o : fill status
module fpnew_order_fifo import fpnew_pkg::*; #(
    parameter int unsigned Depth    = 8,
    parameter int unsigned IdxWidth = 1,
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntWidth = order_cnt_width(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                push_i,
    input  logic [IdxWidth-1:0] data_i,
    input  logic                pop_i,
    output logic [IdxWidth-1:0] data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] usage_o
);

    logic [IdxWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                push_ok, pop_ok;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) wr_d = ptr_inc(wr_q);
            if (pop_ok)  rd_d = ptr_inc(rd_q);
            if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
            else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage needs no reset: entries are only read while counted.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/fpnew_opgroup_order_arbiter.sv
// Dispatch / result-merge stage in front of NumSlices parallel opgroup slices.
// Ordered = ORDER_ISSUE: results leave in issue order via an index FIFO,
//   only the head slice is offered ready, zero added latency.
// Ordered = ORDER_RR: round-robin over valid slices; a stalled grant is
//   locked so data_o/idx_o stay stable until the handshake.
//   in_*        : operation handshake; in_slice_i picks the target slice
//   slice_in_*  : per-slice issue handshake
//   slice_out_* / slice_data_i : per-slice results
//   out_*, data_o, idx_o : merged result and the slice that produced it
//   occupancy_o, busy_o  : outstanding-operation count
module fpnew_opgroup_order_arbiter import fpnew_pkg::*; #(
    parameter int unsigned NumSlices = 5,
    parameter int unsigned Depth     = 8,
    parameter order_mode_e Ordered   = ORDER_ISSUE,
    parameter type         DataType  = logic,
    localparam int unsigned IdxWidth = (NumSlices > 1) ? $clog2(NumSlices) : 1,
    localparam int unsigned CntWidth = order_cnt_width(Depth)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [IdxWidth-1:0]           in_slice_i,
    output logic [NumSlices-1:0]          slice_in_valid_o,
    input  logic [NumSlices-1:0]          slice_in_ready_i,
    input  logic [NumSlices-1:0]          slice_out_valid_i,
    output logic [NumSlices-1:0]          slice_out_ready_o,
    input  DataType [NumSlices-1:0]       slice_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output DataType                       data_o,
    output logic [IdxWidth-1:0]           idx_o,
    output logic [CntWidth-1:0]           occupancy_o,
    output logic                          busy_o
);

    logic                full, empty, push, pop, sel_in_ready;
    logic [CntWidth-1:0] occ;

    // An out-of-range in_slice_i matches no k, so sel_in_ready stays 0 and
    // the operation is never accepted.
    always_comb begin
        sel_in_ready     = 1'b0;
        slice_in_valid_o = '0;
        for (int k = 0; k < NumSlices; k++) begin
            if (in_slice_i == IdxWidth'(k)) begin
                sel_in_ready        = slice_in_ready_i[k];
                slice_in_valid_o[k] = in_valid_i & ~full & ~flush_i;
            end
        end
    end

    // Full blocks issue even if a pop happens this cycle: no ready path
    // from out_ready_i back to in_ready_o.
    assign push        = in_valid_i & sel_in_ready & ~full & ~flush_i;
    assign in_ready_o  = push;
    assign occupancy_o = occ;
    assign busy_o      = (occ != '0);
    assign pop         = out_valid_o & out_ready_i;

    if (Ordered == ORDER_ISSUE) begin : gen_issue
        logic [IdxWidth-1:0] head;

        fpnew_order_fifo #(
            .Depth    (Depth),
            .IdxWidth (IdxWidth)
        ) i_order_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (push),
            .data_i  (in_slice_i),
            .pop_i   (pop),
            .data_o  (head),
            .full_o  (full),
            .empty_o (empty),
            .usage_o (occ)
        );

        // Only the oldest operation's slice may hand over; a younger slice
        // with a finished result simply waits for its turn.
        always_comb begin
            out_valid_o       = 1'b0;
            data_o            = '0;
            idx_o             = head;
            slice_out_ready_o = '0;
            for (int k = 0; k < NumSlices; k++) begin
                if (head == IdxWidth'(k)) begin
                    out_valid_o          = ~empty & slice_out_valid_i[k] & ~flush_i;
                    data_o               = slice_data_i[k];
                    slice_out_ready_o[k] = ~empty & out_ready_i;
                end
            end
        end
    end else begin : gen_rr
        logic [CntWidth-1:0] cnt_q, cnt_d;
        logic [IdxWidth-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, grant;
        logic                lock_q, lock_d, found;
        int                  cand;

        assign occ   = cnt_q;
        assign full  = (cnt_q == CntWidth'(Depth));
        assign empty = (cnt_q == '0);

        // Scan downwards so the candidate closest to rr_q is written last
        // and therefore wins.
        always_comb begin
            found = 1'b0;
            grant = rr_q;
            cand  = 0;
            if (lock_q) begin
                grant = lock_idx_q;
                for (int k = 0; k < NumSlices; k++)
                    if (lock_idx_q == IdxWidth'(k)) found = slice_out_valid_i[k];
            end else begin
                for (int i = int'(NumSlices) - 1; i >= 0; i--) begin
                    cand = (int'(rr_q) + i) % int'(NumSlices);
                    if (slice_out_valid_i[cand]) begin
                        found = 1'b1;
                        grant = IdxWidth'(cand);
                    end
                end
            end
        end

        // A result cannot exist without an outstanding operation, so empty
        // also masks valid (keeps the counter from underflowing).
        always_comb begin
            out_valid_o       = found & ~empty & ~flush_i;
            data_o            = '0;
            idx_o             = grant;
            slice_out_ready_o = '0;
            for (int k = 0; k < NumSlices; k++) begin
                if (grant == IdxWidth'(k)) begin
                    data_o               = slice_data_i[k];
                    slice_out_ready_o[k] = out_valid_o & out_ready_i;
                end
            end
        end

        always_comb begin
            cnt_d      = cnt_q;
            rr_d       = rr_q;
            lock_d     = lock_q;
            lock_idx_d = lock_idx_q;
            if (flush_i) begin
                cnt_d      = '0;
                rr_d       = '0;
                lock_d     = 1'b0;
                lock_idx_d = '0;
            end else begin
                if (push && !pop)      cnt_d = cnt_q + 1'b1;
                else if (pop && !push) cnt_d = cnt_q - 1'b1;
                if (pop) begin
                    lock_d = 1'b0;
                    rr_d   = (grant == IdxWidth'(NumSlices - 1)) ? '0 : grant + 1'b1;
                end else if (out_valid_o) begin
                    lock_d     = 1'b1;
                    lock_idx_d = grant;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q      <= '0;
                rr_q       <= '0;
                lock_q     <= 1'b0;
                lock_idx_q <= '0;
            end else begin
                cnt_q      <= cnt_d;
                rr_q       <= rr_d;
                lock_q     <= lock_d;
                lock_idx_q <= lock_idx_d;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> !empty);
    a_valid_le_occ : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (Ordered != ORDER_ISSUE) || ($countones(slice_out_valid_i) <= int'(occ)));
    a_slice_range  : assert property (@(posedge clk_i) disable iff (!rst_ni)
        in_valid_i |-> (int'(in_slice_i) < int'(NumSlices)));
`endif

endmodule
